// File: rtl/mc6809_irq_pkg.sv
// Shared constants and types for the MC6809 interrupt controller.
// Register window offsets, source count and the vector-fetch ack FSM states.
package mc6809_irq_pkg;

  localparam int unsigned NSRC = 8;

  // Register offsets within the 8-byte window
  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_FSEL   = 3'd2;
  localparam logic [2:0] OFF_VECHI  = 3'd3;
  localparam logic [2:0] OFF_VECLO  = 3'd4;
  localparam logic [2:0] OFF_ACT    = 3'd5;
  localparam logic [2:0] OFF_TRLDHI = 3'd6;
  localparam logic [2:0] OFF_TRLDLO = 3'd7;

  typedef enum logic {
    StIdle,
    StAck
  } ack_state_e;

endpackage

// File: rtl/mc6809_irq_prio.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module mc6809_irq_prio
  import mc6809_irq_pkg::*;
(
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      idx
);

  // Scan from the top so the lowest set index is the last assignment to stick
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/mc6809_irq_ctrl.sv
// MC6809 interrupt controller, responder side of the nIRQ/nFIRQ protocol.
// Edge-detects eight request lines, routes them to IRQ or FIRQ, and supplies
// the per-source vector during the CPU vector fetch (BS=1, BA=0).
// Optional feature: define MC6809_IRQ_TIMER_EN to add a reloadable 16-bit
// down-counter at offsets 6/7 that raises PEND[7] on each expiry.
module mc6809_irq_ctrl
  import mc6809_irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF80,
  parameter logic [15:0] VEC_DEFAULT = 16'hFFF8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic        RnW,
  input  logic        CYC,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        DSEL,
  input  logic        BS,
  input  logic        BA,
  input  logic [7:0]  SRC,
  output logic        nIRQ,
  output logic        nFIRQ,
  output logic [15:0] INTVECTOR
);

  logic       hit;
  logic       wr;
  logic [2:0] off;

  logic [7:0] src_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q;
  logic [7:0] fsel_q;
  logic [7:0] vechi_q;
  logic [7:0] veclo_q;
  logic [7:0] rise;
  logic [7:0] tmr_set;

  logic [7:0] fpend;
  logic [7:0] ipend;
  logic       f_valid, i_valid;
  logic [2:0] f_idx, i_idx;
  logic       sel_valid;
  logic [2:0] sel_idx;
  logic [15:0] live_vec;

  ack_state_e  state_q;
  logic [2:0]  ack_idx_q;
  logic        ack_valid_q;
  logic [15:0] vec_q;
  logic        ack_req;
  logic        ack_done;

  logic [7:0] rdata;
  logic       nirq_q, nfirq_q;

  assign hit  = CYC & (ADDR[15:3] == BASE_ADDR[15:3]);
  assign wr   = hit & ~RnW;
  assign off  = ADDR[2:0];
  assign DSEL = hit & RnW;

  // Vector-fetch acknowledge is BS=1, BA=0; halt/grant (11) and SYNC (01) never qualify
  assign ack_req  = CYC & BS & ~BA;
  assign ack_done = CYC & ~(BS & ~BA);

  assign rise = SRC & ~src_q;

  // ---------------------------------------------------------------------------
  // Optional interval timer feeding PEND[7]
  // ---------------------------------------------------------------------------
`ifdef MC6809_IRQ_TIMER_EN
  logic [7:0]  rldhi_q, rldlo_q;
  logic [15:0] rld_new;
  logic [15:0] cnt_q;
  logic        rld_wr;

  // Merge a reload byte write into the reload value so a write restarts from it
  always_comb begin
    rld_new = {rldhi_q, rldlo_q};
    rld_wr  = wr & ((off == OFF_TRLDHI) | (off == OFF_TRLDLO));
    if (wr && (off == OFF_TRLDHI)) rld_new[15:8] = DIN;
    if (wr && (off == OFF_TRLDLO)) rld_new[7:0]  = DIN;
    tmr_set = {~rld_wr & (|{rldhi_q, rldlo_q}) & (cnt_q == 16'd0), 7'd0};
  end

  // Down-counter: reloads on expiry, restarts on any reload write, idles at reload 0
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rldhi_q <= 8'h00;
      rldlo_q <= 8'h00;
      cnt_q   <= 16'd0;
    end else begin
      rldhi_q <= rld_new[15:8];
      rldlo_q <= rld_new[7:0];
      if (rld_wr) begin
        cnt_q <= rld_new;
      end else if (|{rldhi_q, rldlo_q}) begin
        if (cnt_q == 16'd0) cnt_q <= {rldhi_q, rldlo_q};
        else                cnt_q <= cnt_q - 16'd1;
      end
    end
  end
`else
  assign tmr_set = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Pending register: W1C and ack-clear first, then new edges so a set always wins
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    if (wr && (off == OFF_PEND)) pend_d = pend_d & ~DIN;
    if ((state_q == StAck) && ack_done && ack_valid_q) pend_d[ack_idx_q] = 1'b0;
    pend_d = pend_d | rise | tmr_set;
  end

  // Request synchroniser-free edge capture and pending state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_q  <= 8'h00;
      pend_q <= 8'h00;
    end else begin
      src_q  <= SRC;
      pend_q <= pend_d;
    end
  end

  // CPU-writable configuration registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q  <= 8'h00;
      fsel_q  <= 8'h00;
      vechi_q <= VEC_DEFAULT[15:8];
      veclo_q <= VEC_DEFAULT[7:0];
    end else if (wr) begin
      case (off)
        OFF_MASK:  mask_q  <= DIN;
        OFF_FSEL:  fsel_q  <= DIN;
        OFF_VECHI: vechi_q <= DIN;
        OFF_VECLO: veclo_q <= DIN;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Priority selection: any FIRQ source beats every IRQ source
  // ---------------------------------------------------------------------------
  assign fpend = pend_q & mask_q & fsel_q;
  assign ipend = pend_q & mask_q & ~fsel_q;

  mc6809_irq_prio u_prio_firq (
    .req   (fpend),
    .valid (f_valid),
    .idx   (f_idx)
  );

  mc6809_irq_prio u_prio_irq (
    .req   (ipend),
    .valid (i_valid),
    .idx   (i_idx)
  );

  assign sel_valid = f_valid | i_valid;
  assign sel_idx   = f_valid ? f_idx : (i_valid ? i_idx : 3'd0);
  // Two bytes per vector slot; wraps modulo 2^16
  assign live_vec  = {vechi_q, veclo_q} + {12'd0, sel_idx, 1'b0};

  // Registered interrupt lines to the CPU
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nirq_q  <= 1'b1;
      nfirq_q <= 1'b1;
    end else begin
      nirq_q  <= ~|ipend;
      nfirq_q <= ~|fpend;
    end
  end

  assign nIRQ  = nirq_q;
  assign nFIRQ = nfirq_q;

  // Ack FSM: freeze the selection for the whole vector fetch, clear it on exit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      ack_idx_q   <= 3'd0;
      ack_valid_q <= 1'b0;
      vec_q       <= VEC_DEFAULT;
    end else begin
      case (state_q)
        StIdle: begin
          if (ack_req) begin
            state_q     <= StAck;
            ack_idx_q   <= sel_idx;
            ack_valid_q <= sel_valid;
            vec_q       <= live_vec;
          end
        end
        StAck: begin
          if (ack_done) begin
            state_q     <= StIdle;
            ack_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Live selection while idle, frozen vector during the fetch
  assign INTVECTOR = (state_q == StAck) ? vec_q : live_vec;

  // ---------------------------------------------------------------------------
  // Read mux, zero-latency
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_PEND:   rdata = pend_q;
      OFF_MASK:   rdata = mask_q;
      OFF_FSEL:   rdata = fsel_q;
      OFF_VECHI:  rdata = vechi_q;
      OFF_VECLO:  rdata = veclo_q;
      OFF_ACT:    rdata = {sel_valid, 4'b0000, sel_idx};
`ifdef MC6809_IRQ_TIMER_EN
      OFF_TRLDHI: rdata = rldhi_q;
      OFF_TRLDLO: rdata = rldlo_q;
`endif
      default:    rdata = 8'h00;
    endcase
  end

  assign DOUT = DSEL ? rdata : 8'h00;

endmodule
